dma_job_scheduler: RTL and testbench

- Shares the single DMA read/write controller between NUM_REQ job requesters, e.g. ifmap load, weight load and ofmap store.
- Arbitrates round-robin and latches the winner's job descriptor (read base, write base, transfers per block, block count).
- Pulses start to the DMA controller, waits for its write-done pulse, then reports completion to the winning requester.
- Sits between the layer sequencer and the DMA controller.

---
 rtl/dma_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/dma_job_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_dma_job_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_sched_pkg.sv
// Shared constants and types for the DMA job scheduler.
//   state_e   : scheduler FSM encoding (IDLE=0, START=1, RUN=2, DONE=3)
//   BLK_W     : width of the block-count field in a job descriptor
//   GID_W     : width of the grant index (enough for up to 8 requesters)
//   TO_CNT_W  : width of the optional RUN-state watchdog counter
package dma_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BLK_W    = 16;
    localparam int GID_W    = 3;
    localparam int TO_CNT_W = 21;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Finds the first set request at or after ptr_i, searching upward and
// wrapping at N-1. ptr_i must be below N.
//   req_i    : request vector
//   ptr_i    : round-robin start position
//   valid_o  : at least one request set
//   grant_o  : one-hot winner
//   idx_o    : winner index
module rr_arbiter
    import dma_sched_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [GID_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [N-1:0]     grant_o,
    output logic [GID_W-1:0] idx_o
);

    int winner;

    // Walk offsets from far to near so the smallest offset from the pointer
    // is the last assignment and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        winner  = 0;
        for (int j = N - 1; j >= 0; j--) begin
            for (int m = 0; m < N; m++) begin
                if ((((int'(ptr_i) + j) % N) == m) && req_i[m]) begin
                    valid_o = 1'b1;
                    winner  = m;
                end
            end
        end
    end

    always_comb begin
        grant_o = '0;
        for (int m = 0; m < N; m++) begin
            grant_o[m] = valid_o && (winner == m);
        end
        idx_o = GID_W'(winner);
    end

endmodule

// File: rtl/dma_job_scheduler.sv
// Shares one DMA read/write controller between NUM_REQ job requesters.
// Round-robin grant, descriptor latch, start pulse, wait for write-done,
// then a done pulse back to the winner.
// Optional watchdog: define DMA_SCHED_TIMEOUT_EN to abort a RUN that lasts
// TIMEOUT_CYC cycles (sets sticky o_timeout, still issues o_done).
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   i_req                     level requests, held until o_ack
//   i_base_rd/i_base_wr       packed read/write base addresses per requester
//   i_num_trans/i_max_blk     packed transfers-per-block / block counts
//   o_ack/o_done              per-requester capture / completion pulses
//   o_busy, o_grant_id        job in flight, current or last winner
//   o_dma_*                   start pulse and latched descriptor to the DMA
//   i_dma_wr_done             DMA last-block write-done pulse
//   o_timeout                 watchdog flag (0 when feature not built)
//
// state | meaning
// IDLE  | waiting for a request; grant and latch on the same edge
// START | issue the DMA start pulse (skipped for a zero-block job)
// RUN   | DMA active, waiting for write-done
// DONE  | pulse o_done, advance the round-robin pointer
module dma_job_scheduler
    import dma_sched_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int BIT_TRANS    = 18,
    parameter int AXI_WIDTH_AD = 32,
    parameter int TIMEOUT_CYC  = 1048576
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_REQ-1:0]                i_req,
    input  logic [NUM_REQ*AXI_WIDTH_AD-1:0]   i_base_rd,
    input  logic [NUM_REQ*AXI_WIDTH_AD-1:0]   i_base_wr,
    input  logic [NUM_REQ*BIT_TRANS-1:0]      i_num_trans,
    input  logic [NUM_REQ*BLK_W-1:0]          i_max_blk,
    output logic [NUM_REQ-1:0]                o_ack,
    output logic [NUM_REQ-1:0]                o_done,
    output logic                              o_busy,
    output logic [GID_W-1:0]                  o_grant_id,
    output logic                              o_dma_start,
    output logic [AXI_WIDTH_AD-1:0]           o_dma_base_rd,
    output logic [AXI_WIDTH_AD-1:0]           o_dma_base_wr,
    output logic [BIT_TRANS-1:0]              o_dma_num_trans,
    output logic [BLK_W-1:0]                  o_dma_max_blk,
    input  logic                              i_dma_wr_done,
    output logic                              o_timeout
);

    state_e                  state_q, state_d;
    logic [GID_W-1:0]        ptr_q, ptr_d;
    logic [GID_W-1:0]        gid_q, gid_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    start_q, start_d;
    logic [AXI_WIDTH_AD-1:0] rd_q, rd_d;
    logic [AXI_WIDTH_AD-1:0] wr_q, wr_d;
    logic [BIT_TRANS-1:0]    nt_q, nt_d;
    logic [BLK_W-1:0]        mb_q, mb_d;

    logic                    arb_valid;
    logic [NUM_REQ-1:0]      arb_grant;
    logic [GID_W-1:0]        arb_idx;

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);
    logic [TO_CNT_W-1:0]     cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .valid_o (arb_valid),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        start_d = 1'b0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        nt_d    = nt_q;
        mb_d    = mb_q;
`ifdef DMA_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gid_d  = arb_idx;
                    ack_d  = arb_grant;
                    busy_d = 1'b1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (arb_grant[k]) begin
                            rd_d = i_base_rd[k*AXI_WIDTH_AD +: AXI_WIDTH_AD];
                            wr_d = i_base_wr[k*AXI_WIDTH_AD +: AXI_WIDTH_AD];
                            nt_d = i_num_trans[k*BIT_TRANS +: BIT_TRANS];
                            mb_d = i_max_blk[k*BLK_W +: BLK_W];
                        end
                    end
                    state_d = START;
                end
            end
            START: begin
                // A zero-block job never touches the DMA controller.
                if (mb_q == '0) begin
                    state_d = DONE;
                end else begin
                    start_d = 1'b1;
                    state_d = RUN;
`ifdef DMA_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            RUN: begin
                if (i_dma_wr_done) begin
                    state_d = DONE;
                end
`ifdef DMA_SCHED_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    done_d[k] = (gid_q == GID_W'(k));
                end
                busy_d  = 1'b0;
                ptr_d   = (gid_q == GID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            nt_q    <= '0;
            mb_q    <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            nt_q    <= nt_d;
            mb_q    <= mb_d;
`ifdef DMA_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_ack           = ack_q;
    assign o_done          = done_q;
    assign o_busy          = busy_q;
    assign o_grant_id      = gid_q;
    assign o_dma_start     = start_q;
    assign o_dma_base_rd   = rd_q;
    assign o_dma_base_wr   = wr_q;
    assign o_dma_num_trans = nt_q;
    assign o_dma_max_blk   = mb_q;
`ifdef DMA_SCHED_TIMEOUT_EN
    assign o_timeout       = timeout_q;
`else
    assign o_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed bench for dma_job_scheduler (3 requesters, watchdog limit 64).
module tb_dma_job_scheduler;

    localparam int NR = 3;
    localparam int BT = 18;
    localparam int AW = 32;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     i_req;
    logic [NR*AW-1:0]  i_base_rd;
    logic [NR*AW-1:0]  i_base_wr;
    logic [NR*BT-1:0]  i_num_trans;
    logic [NR*16-1:0]  i_max_blk;
    logic [NR-1:0]     o_ack;
    logic [NR-1:0]     o_done;
    logic              o_busy;
    logic [2:0]        o_grant_id;
    logic              o_dma_start;
    logic [AW-1:0]     o_dma_base_rd;
    logic [AW-1:0]     o_dma_base_wr;
    logic [BT-1:0]     o_dma_num_trans;
    logic [15:0]       o_dma_max_blk;
    logic              i_dma_wr_done;
    logic              o_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_total = 0;
    int done_total = 0;
    int start_total = 0;
    int snap_ack, snap_done, snap_start;

    dma_job_scheduler #(
        .NUM_REQ(NR), .BIT_TRANS(BT), .AXI_WIDTH_AD(AW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .i_req(i_req),
        .i_base_rd(i_base_rd), .i_base_wr(i_base_wr),
        .i_num_trans(i_num_trans), .i_max_blk(i_max_blk),
        .o_ack(o_ack), .o_done(o_done), .o_busy(o_busy),
        .o_grant_id(o_grant_id), .o_dma_start(o_dma_start),
        .o_dma_base_rd(o_dma_base_rd), .o_dma_base_wr(o_dma_base_wr),
        .o_dma_num_trans(o_dma_num_trans), .o_dma_max_blk(o_dma_max_blk),
        .i_dma_wr_done(i_dma_wr_done), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        ack_total   += $countones(o_ack);
        done_total  += $countones(o_done);
        start_total += int'(o_dma_start);
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int k, input logic [31:0] rd, input logic [31:0] wr,
                            input logic [17:0] nt, input logic [15:0] mb);
        i_base_rd[k*AW +: AW]   = rd;
        i_base_wr[k*AW +: AW]   = wr;
        i_num_trans[k*BT +: BT] = nt;
        i_max_blk[k*16 +: 16]   = mb;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_ack"},   64'(o_ack), 64'd0);
        chk_val({tag, "_done"},  64'(o_done), 64'd0);
        chk_val({tag, "_busy"},  64'(o_busy), 64'd0);
        chk_val({tag, "_gid"},   64'(o_grant_id), 64'd0);
        chk_val({tag, "_start"}, 64'(o_dma_start), 64'd0);
        chk_val({tag, "_rd"},    64'(o_dma_base_rd), 64'd0);
        chk_val({tag, "_wr"},    64'(o_dma_base_wr), 64'd0);
        chk_val({tag, "_nt"},    64'(o_dma_num_trans), 64'd0);
        chk_val({tag, "_mb"},    64'(o_dma_max_blk), 64'd0);
        chk_val({tag, "_to"},    64'(o_timeout), 64'd0);
    endtask

    // One round-robin job with requests held; id is the expected winner.
    task automatic do_job(input int id, input logic [31:0] rd);
        int n;
        logic [NR-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        n = 0;
        do begin
            tick;
            n++;
        end while (o_ack == '0 && n < 10);
        chk_val("rr_ack", 64'(o_ack), 64'(oh));
        chk_val("rr_gid", 64'(o_grant_id), 64'(id));
        tick;
        chk_val("rr_start", 64'(o_dma_start), 64'd1);
        chk_val("rr_rd", 64'(o_dma_base_rd), 64'(rd));
        tick;
        tick;
        i_dma_wr_done = 1'b1;
        tick;
        i_dma_wr_done = 1'b0;
        tick;
        chk_val("rr_done", 64'(o_done), 64'(oh));
        chk_val("rr_busy", 64'(o_busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        rstn          = 1'b0;
        i_req         = '0;
        i_base_rd     = '0;
        i_base_wr     = '0;
        i_num_trans   = '0;
        i_max_blk     = '0;
        i_dma_wr_done = 1'b0;
        tick; tick; tick;
        chk_all_zero("rst");
        rstn = 1'b1;

        // Single job on requester 0; this point is cycle 0.
        set_desc(0, 32'h1000, 32'h2000, 18'd16, 16'd4);
        set_desc(1, 32'hAAAA_0001, 32'hBBBB_0001, 18'd3, 16'd9);
        set_desc(2, 32'hAAAA_0002, 32'hBBBB_0002, 18'd7, 16'd11);
        i_req = 3'b001;
        tick;                                            // cycle 1
        chk_val("s_ack", 64'(o_ack), 64'h1);
        chk_val("s_busy", 64'(o_busy), 64'd1);
        chk_val("s_start_early", 64'(o_dma_start), 64'd0);
        i_req = 3'b000;
        tick;                                            // cycle 2
        chk_val("s_start", 64'(o_dma_start), 64'd1);
        chk_val("s_ack_clr", 64'(o_ack), 64'd0);
        chk_val("s_rd", 64'(o_dma_base_rd), 64'h1000);
        chk_val("s_wr", 64'(o_dma_base_wr), 64'h2000);
        chk_val("s_nt", 64'(o_dma_num_trans), 64'd16);
        chk_val("s_mb", 64'(o_dma_max_blk), 64'd4);
        tick;                                            // cycle 3
        chk_val("s_start_one", 64'(o_dma_start), 64'd0);
        for (int c = 4; c <= 19; c++) tick;              // cycle 19
        chk_val("s_run_busy", 64'(o_busy), 64'd1);
        chk_val("s_run_done", 64'(o_done), 64'd0);
        chk_val("s_run_rd", 64'(o_dma_base_rd), 64'h1000);
        i_dma_wr_done = 1'b1;
        tick;                                            // cycle 20
        i_dma_wr_done = 1'b0;
        chk_val("s_done_early", 64'(o_done), 64'd0);
        tick;                                            // cycle 21
        chk_val("s_done", 64'(o_done), 64'h1);
        chk_val("s_busy_clr", 64'(o_busy), 64'd0);
        tick;
        chk_val("s_done_one", 64'(o_done), 64'd0);

        // Round-robin from pointer 0 with all requests held.
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        for (int k = 0; k < NR; k++) begin
            set_desc(k, 32'h100 * (k + 1), 32'h200 * (k + 1), 18'(k + 1), 16'(k + 2));
        end
        snap_ack  = ack_total;
        snap_done = done_total;
        i_req = 3'b111;
        do_job(0, 32'h100);
        do_job(1, 32'h200);
        do_job(2, 32'h300);
        do_job(0, 32'h100);
        i_req = 3'b000;
        tick;
        chk_val("rr_ack_count", 64'(ack_total - snap_ack), 64'd4);
        chk_val("rr_done_count", 64'(done_total - snap_done), 64'd4);

        // Zero-block job on requester 1.
        set_desc(1, 32'h5000, 32'h6000, 18'd8, 16'd0);
        snap_start = start_total;
        i_req = 3'b010;
        tick;
        chk_val("z_ack", 64'(o_ack), 64'h2);
        i_req = 3'b000;
        tick;
        chk_val("z_start", 64'(o_dma_start), 64'd0);
        chk_val("z_done_early", 64'(o_done), 64'd0);
        tick;
        chk_val("z_done", 64'(o_done), 64'h2);
        chk_val("z_busy", 64'(o_busy), 64'd0);
        tick;
        chk_val("z_start_count", 64'(start_total - snap_start), 64'd0);

        // Inputs disturbed during START must not leak into the job.
        set_desc(2, 32'h3000, 32'h4000, 18'd5, 16'd7);
        i_req = 3'b100;
        tick;
        chk_val("d_ack", 64'(o_ack), 64'h4);
        set_desc(2, 32'hDEAD_0000, 32'hBEEF_0000, 18'd99, 16'd55);
        i_req = 3'b111;
        i_dma_wr_done = 1'b1;
        tick;
        i_dma_wr_done = 1'b0;
        i_req = 3'b000;
        chk_val("d_start", 64'(o_dma_start), 64'd1);
        chk_val("d_rd", 64'(o_dma_base_rd), 64'h3000);
        chk_val("d_wr", 64'(o_dma_base_wr), 64'h4000);
        chk_val("d_nt", 64'(o_dma_num_trans), 64'd5);
        chk_val("d_mb", 64'(o_dma_max_blk), 64'd7);
        tick; tick; tick;
        chk_val("d_still_busy", 64'(o_busy), 64'd1);
        chk_val("d_no_done", 64'(o_done), 64'd0);
        chk_val("d_no_ack", 64'(o_ack), 64'd0);

        // One-cycle reset while in RUN.
        snap_done = done_total;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        chk_all_zero("mr");
        tick;
        chk_val("mr_no_done", 64'(done_total - snap_done), 64'd0);
        set_desc(1, 32'h7000, 32'h8000, 18'd2, 16'd3);
        i_req = 3'b110;
        tick;
        chk_val("mr_ack", 64'(o_ack), 64'h2);
        chk_val("mr_gid", 64'(o_grant_id), 64'd1);
        i_req = 3'b000;
        tick;
        chk_val("mr_start", 64'(o_dma_start), 64'd1);
        chk_val("mr_rd", 64'(o_dma_base_rd), 64'h7000);

        // Long RUN without write-done.
        for (int c = 0; c < TO - 1; c++) tick;
        chk_val("to_before", 64'(o_timeout), 64'd0);
        chk_val("to_busy_before", 64'(o_busy), 64'd1);
`ifdef DMA_SCHED_TIMEOUT_EN
        tick;
        chk_val("to_rise", 64'(o_timeout), 64'd1);
        tick;
        chk_val("to_done", 64'(o_done), 64'h2);
        chk_val("to_busy_clr", 64'(o_busy), 64'd0);
        tick;
        chk_val("to_sticky", 64'(o_timeout), 64'd1);
        chk_val("to_done_one", 64'(o_done), 64'd0);
`else
        tick; tick; tick;
        chk_val("to_never", 64'(o_timeout), 64'd0);
        chk_val("to_wait_busy", 64'(o_busy), 64'd1);
        chk_val("to_wait_done", 64'(o_done), 64'd0);
        i_dma_wr_done = 1'b1;
        tick;
        i_dma_wr_done = 1'b0;
        tick;
        chk_val("to_final_done", 64'(o_done), 64'h2);
        chk_val("to_final_flag", 64'(o_timeout), 64'd0);
`endif
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
